// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the ROM instruction fetcher.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      CAP  = 3'd2,
      OUT  = 3'd3,
      HALT = 3'd4
   } fetch_state_t;

   localparam int          DEF_ADR_W     = 8;
   localparam int          DEF_DAT_W     = 32;
   localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry valid/ready FIFO used as the output buffer of the pipelined fetcher.
module fetch_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         flush,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   output logic         pop_vld,
   output logic [W-1:0] pop_dat,
   input  logic         pop_rdy,
   output logic [1:0]   level
);

   logic [W-1:0] mem_reg [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   level_reg;
   logic         push_fire;
   logic         pop_fire;

   assign push_fire = push_vld && (level_reg != 2'd2);
   assign pop_fire  = pop_rdy && (level_reg != 2'd0);
   assign pop_vld   = (level_reg != 2'd0);
   assign pop_dat   = mem_reg[rd_ptr_reg];
   assign level     = level_reg;

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         level_reg  <= 2'd0;
      end else begin
         if (push_fire) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop_fire)  rd_ptr_reg <= ~rd_ptr_reg;
         level_reg <= level_reg + {1'b0, push_fire} - {1'b0, pop_fire};
      end
   end

   // Storage carries no reset; the level counter alone decides what is valid.
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (push_fire && (wr_ptr_reg == 1'(gi))) mem_reg[gi] <= push_dat;
      end
   end

endmodule

// File: rtl/rom_fetch.sv
// Sequential instruction fetcher for a ROM with one-cycle registered read.
// Define FETCH_PIPE_EN for one-word-per-cycle issue through a 2-entry output buffer.
module rom_fetch
   import fetch_pkg::*;
#(
   parameter int               ADR_W     = DEF_ADR_W,
   parameter int               DAT_W     = DEF_DAT_W,
   parameter logic [DAT_W-1:0] HALT_WORD = DAT_W'(DEF_HALT_WORD)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             jmp_i,
   input  logic [ADR_W-1:0] jmp_adr_i,
   output logic [ADR_W-1:0] adr_o,
   input  logic [DAT_W-1:0] dat_i,
   output logic [DAT_W-1:0] ins_o,
   output logic [ADR_W-1:0] pc_o,
   output logic             vld_o,
   input  logic             rdy_i,
   output logic             halt_o
);

   logic [ADR_W-1:0] pc_reg;

   assign adr_o = pc_reg;

`ifdef FETCH_PIPE_EN

   logic             inflight_reg;
   logic [ADR_W-1:0] inflight_pc_reg;
   logic             halt_reg;
   logic [ADR_W-1:0] halt_pc_reg;
   logic             hit_halt;
   logic             push_vld;
   logic             pop_fire;
   logic             issue;
   logic             buf_vld;
   logic [1:0]       buf_level;
   logic [2:0]       occ_after;
   logic [ADR_W+DAT_W-1:0] buf_dat;

   assign hit_halt  = inflight_reg && (dat_i == HALT_WORD);
   assign push_vld  = inflight_reg && !hit_halt && !jmp_i;
   assign pop_fire  = buf_vld && rdy_i;
   // Issue only if the word returning next cycle is guaranteed a buffer slot.
   assign occ_after = {1'b0, buf_level} + {2'b00, push_vld} - {2'b00, pop_fire};
   assign issue     = run_i && !halt_reg && !hit_halt && !jmp_i && (occ_after <= 3'd1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_reg          <= '0;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
         halt_reg        <= 1'b0;
         halt_pc_reg     <= '0;
      end else if (jmp_i) begin
         pc_reg       <= jmp_adr_i;
         inflight_reg <= 1'b0;
         halt_reg     <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (issue) begin
            pc_reg          <= pc_reg + ADR_W'(1);
            inflight_pc_reg <= pc_reg;
         end
         if (hit_halt) begin
            halt_reg    <= 1'b1;
            halt_pc_reg <= inflight_pc_reg;
         end
      end
   end

   fetch_buf #(.W(ADR_W + DAT_W)) u_buf (
      .clk      (clk_i),
      .srst     (rst_i),
      .flush    (jmp_i),
      .push_vld (push_vld),
      .push_dat ({inflight_pc_reg, dat_i}),
      .pop_vld  (buf_vld),
      .pop_dat  (buf_dat),
      .pop_rdy  (rdy_i),
      .level    (buf_level)
   );

   // Halt is reported only once every word fetched before it has drained.
   assign vld_o  = buf_vld;
   assign ins_o  = buf_vld ? buf_dat[DAT_W-1:0] : '0;
   assign pc_o   = buf_vld ? buf_dat[ADR_W+DAT_W-1:DAT_W] : halt_pc_reg;
   assign halt_o = halt_reg && !buf_vld;

`else

   fetch_state_t     state_reg, state_next;
   logic [ADR_W-1:0] pc_next;
   logic [DAT_W-1:0] ins_reg, ins_next;
   logic [ADR_W-1:0] out_pc_reg, out_pc_next;
   logic             vld_reg, vld_next;
   logic             halt_reg, halt_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         pc_reg     <= '0;
         ins_reg    <= '0;
         out_pc_reg <= '0;
         vld_reg    <= 1'b0;
         halt_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         ins_reg    <= ins_next;
         out_pc_reg <= out_pc_next;
         vld_reg    <= vld_next;
         halt_reg   <= halt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      ins_next    = ins_reg;
      out_pc_next = out_pc_reg;
      vld_next    = vld_reg;
      halt_next   = halt_reg;
      case (state_reg)
         IDLE: if (run_i) state_next = REQ;
         REQ:  state_next = CAP;
         CAP: begin
            out_pc_next = pc_reg;
            if (dat_i == HALT_WORD) begin
               halt_next  = 1'b1;
               state_next = HALT;
            end else begin
               ins_next   = dat_i;
               vld_next   = 1'b1;
               state_next = OUT;
            end
         end
         OUT: if (rdy_i) begin
            vld_next   = 1'b0;
            pc_next    = pc_reg + ADR_W'(1);
            state_next = run_i ? REQ : IDLE;
         end
         HALT: state_next = HALT;
         default: state_next = IDLE;
      endcase
      // A jump overrides everything, including a transfer at the same edge.
      if (jmp_i) begin
         pc_next    = jmp_adr_i;
         vld_next   = 1'b0;
         halt_next  = 1'b0;
         state_next = run_i ? REQ : IDLE;
      end
   end

   assign ins_o  = ins_reg;
   assign pc_o   = out_pc_reg;
   assign vld_o  = vld_reg;
   assign halt_o = halt_reg;

`endif

endmodule
